food_tracker: RTL and testbench
===============================

Name: food_tracker

Overview:
- Upstream producer of the pellet-per-pixel flag consumed by the colour mapper.
- Holds the pellet map for the 640x352 playfield as a tile-granular bit array.
- Once per frame, clears the pellet under Pac-Man's centre, updates score and pellets remaining, and flags level clear.
- Drives is_food combinationally from DrawX/DrawY with the mapper's polarity: 0 = draw pellet.

Parameters:
TILE_SHIFT, 4, log2 of tile edge in pixels (16x16 tiles)
MAP_COLS, 40, tiles per row
MAP_ROWS, 22, tile rows (22*16 = 352 = playfield height)
DOT_LO, 6, first in-tile pixel offset (x and y) of the pellet dot
DOT_HI, 9, last in-tile pixel offset of the pellet dot (4x4 dot)
POINTS, 10, score added per pellet eaten
POWER_FRAMES, 300, power-mode duration in frames (optional feature only)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
frame_clk  in  1  VGA vertical-sync-rate frame tick, asynchronous to Clk
restart  in  1  synchronous refill request, level-sensitive, sampled on Clk
Ball_X  in  10  Pac-Man centre x, pixels
Ball_Y  in  10  Pac-Man centre y, pixels
DrawX  in  10  current pixel x
DrawY  in  10  current pixel y
is_food  out  1  0 = pixel belongs to a live pellet dot, 1 = no pellet
score  out  16  accumulated score
pellets_left  out  10  live pellet count
level_clear  out  1  high once pellets_left reaches 0
power_mode  out  1  present only with FOOD_POWER_PELLET_EN

Behaviour:
- Reset (async), all taking effect immediately:
  - all MAP_COLS*MAP_ROWS pellet bits = 1
  - pellets_left = 880, score = 0, level_clear = 0, power_mode = 0
  - FSM = IDLE, synchroniser flops = 0
- frame_clk handling:
  - passed through a 2-flop synchroniser, then rising-edge detected
  - the edge detector produces a 1-Clk eat_req pulse
- FSM states IDLE, CHECK, CLEAR, DONE:
  - IDLE: on eat_req, latch Ball_X/Ball_Y and go to CHECK.
  - CHECK:
    - tile = (Ball_Y>>TILE_SHIFT)*MAP_COLS + (Ball_X>>TILE_SHIFT), computed in 10 bits
    - if Ball_X >= 640, Ball_Y >= 352, or the pellet bit is 0, return to IDLE
    - otherwise go to CLEAR
  - CLEAR:
    - clear the pellet bit
    - pellets_left decrements
    - score += POINTS, saturating at 16'hFFFF
    - if pellets_left was 1, go to DONE; otherwise go to IDLE
  - DONE: level_clear = 1; eat_req is ignored; stays in DONE until restart or Reset.
- Latency: bit, score and count update on the 3rd Clk edge after eat_req (IDLE→CHECK→CLEAR). At most one pellet is eaten per frame.
- restart:
  - In one Clk, restores every pellet bit and counter to reset values and forces IDLE.
  - Takes priority over any in-flight CHECK/CLEAR and over a coincident eat_req; that eat is dropped.
- eat_req arriving while not in IDLE is dropped; it cannot occur at legal frame rates.
- is_food is purely combinational, zero latency, aligned with DrawX/DrawY. It is 0 iff all of the following hold, else 1:
  - DrawX < 640 and DrawY < 352
  - the pellet bit of the pixel's tile is 1
  - DrawX[3:0] and DrawY[3:0] both lie in DOT_LO..DOT_HI
- Pellets in wall tiles are never eaten. Wall priority in the mapper hides them; pellets_left reaching 0 therefore requires a maze without walls. Level-clear via a wall mask is a later revision.

Optional Feature:
- Macro FOOD_POWER_PELLET_EN.
- Defined:
  - tiles (1,1), (38,1), (1,20) and (38,20) are power pellets; their dot spans offsets 4..11 (8x8)
  - eating one adds 5*POINTS and loads a frame countdown with POWER_FRAMES
  - power_mode = (countdown != 0); the countdown decrements on each eat_req, saturating at 0
  - eating another power pellet reloads the countdown
  - restart and Reset clear the countdown
- Undefined: the power_mode port and countdown are absent; all tiles behave as normal pellets with 4x4 dots.

Decomposition:
- Package food_pkg:
  - TILE_SHIFT, MAP_COLS, MAP_ROWS, NUM_TILES (880), PLAY_W (640), PLAY_H (352)
  - typedef tile_idx_t (logic [9:0])
  - typedef enum food_state_t {IDLE, CHECK, CLEAR, DONE}
  - power-pellet tile constants
- Sub-module frame_edge_sync: 2-flop synchroniser plus rising-edge pulse, with async active-high Reset.

Test Plan:
- Reset, then scan DrawX=6..9 / DrawY=6..9 → is_food=0. Scan DrawX=5 or 10 → is_food=1. Scan DrawY=352 → is_food=1.
- Ball at (24,24), one frame_clk rise → 3 Clk after eat_req, tile 41 cleared, score=10, pellets_left=879. Pixel (24,24) → is_food=1.
- Same position, second frame → no change (score stays 10).
- Ball_X=650 with a frame tick → no state change.
- restart asserted in the same Clk as eat_req at tile 0 → all bits set, score=0, pellets_left=880, tile 0 still present.
- Force pellets_left=1 via eats on a wall-free map, then eat the last pellet → level_clear=1. Further frames leave score unchanged. Reset mid-CLEAR returns all outputs to reset values immediately.
- FOOD_POWER_PELLET_EN: eat tile (1,1) → score +50, power_mode=1 for 300 frames, low on the 301st frame.

Source files
------------

// File: rtl/food_pkg.sv
// Shared constants, types and tile helpers for the pellet tracker.
// Also holds the power-pellet tile constants used when FOOD_POWER_PELLET_EN is defined.
package food_pkg;

   localparam int TILE_SHIFT   = 4;
   localparam int MAP_COLS     = 40;
   localparam int MAP_ROWS     = 22;
   localparam int NUM_TILES    = MAP_COLS * MAP_ROWS;
   localparam int PLAY_W       = 640;
   localparam int PLAY_H       = 352;
   localparam int DOT_LO       = 6;
   localparam int DOT_HI       = 9;
   localparam int POINTS       = 10;
   localparam int POWER_FRAMES = 300;
   localparam int PWR_DOT_LO   = 4;
   localparam int PWR_DOT_HI   = 11;

   typedef logic [9:0] tile_idx_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      CLEAR = 2'd2,
      DONE  = 2'd3
   } food_state_t;

   // Corner power pellets: (col,row) = (1,1), (38,1), (1,20), (38,20)
   localparam tile_idx_t PWR_TILE_0 = tile_idx_t'(1 * MAP_COLS + 1);
   localparam tile_idx_t PWR_TILE_1 = tile_idx_t'(1 * MAP_COLS + 38);
   localparam tile_idx_t PWR_TILE_2 = tile_idx_t'(20 * MAP_COLS + 1);
   localparam tile_idx_t PWR_TILE_3 = tile_idx_t'(20 * MAP_COLS + 38);

   function automatic tile_idx_t tile_of(input logic [9:0] x, input logic [9:0] y);
      tile_idx_t row;
      tile_idx_t col;
      row = tile_idx_t'(y >> TILE_SHIFT);
      col = tile_idx_t'(x >> TILE_SHIFT);
      return tile_idx_t'(row * tile_idx_t'(MAP_COLS)) + col;
   endfunction

   function automatic logic is_power_tile(input tile_idx_t t);
      return (t == PWR_TILE_0) || (t == PWR_TILE_1) ||
             (t == PWR_TILE_2) || (t == PWR_TILE_3);
   endfunction

endpackage

// File: rtl/food_tracker_frame_edge_sync.sv
// Brings the asynchronous frame tick into the Clk domain and emits a
// single-cycle pulse on each rising edge.
module frame_edge_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic pulse_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= async_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/food_tracker.sv
// Pellet map, eat FSM, score/count bookkeeping and combinational is_food lookup.
// Optional power pellets and power_mode output are enabled by FOOD_POWER_PELLET_EN.
module food_tracker
   import food_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic        restart,
   input  logic [9:0]  Ball_X,
   input  logic [9:0]  Ball_Y,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   output logic        is_food,
   output logic [15:0] score,
   output logic [9:0]  pellets_left,
   output logic        level_clear
`ifdef FOOD_POWER_PELLET_EN
   ,
   output logic        power_mode
`endif
);

   // state   | meaning
   // IDLE    | waiting for a frame tick
   // CHECK   | Ball position latched; test bounds and pellet bit
   // CLEAR   | remove pellet, bump score, decrement count
   // DONE    | level cleared; frame ticks ignored until restart/Reset

   logic                 eat_req;
   food_state_t          state_q, state_d;
   logic [NUM_TILES-1:0] map_q, map_d;
   logic [9:0]           ball_x_q, ball_x_d;
   logic [9:0]           ball_y_q, ball_y_d;
   tile_idx_t            tile_q, tile_d;
   logic [15:0]          score_q, score_d;
   logic [9:0]           left_q, left_d;
   tile_idx_t            ball_tile;
   logic                 ball_pellet;
   logic [16:0]          score_sum;
   logic [15:0]          points;

   frame_edge_sync u_sync (
      .clk_i   (Clk),
      .rst_i   (Reset),
      .async_i (frame_clk),
      .pulse_o (eat_req)
   );

`ifdef FOOD_POWER_PELLET_EN
   logic [8:0] pcnt_q, pcnt_d;
`endif

   assign ball_tile   = tile_of(ball_x_q, ball_y_q);
   assign ball_pellet = (ball_tile < tile_idx_t'(NUM_TILES)) && map_q[ball_tile];

   always_comb begin
`ifdef FOOD_POWER_PELLET_EN
      points = is_power_tile(tile_q) ? 16'(5 * POINTS) : 16'(POINTS);
`else
      points = 16'(POINTS);
`endif
      score_sum = {1'b0, score_q} + {1'b0, points};
   end

   always_comb begin
      state_d  = state_q;
      map_d    = map_q;
      ball_x_d = ball_x_q;
      ball_y_d = ball_y_q;
      tile_d   = tile_q;
      score_d  = score_q;
      left_d   = left_q;
`ifdef FOOD_POWER_PELLET_EN
      pcnt_d   = pcnt_q;
      if (eat_req && (pcnt_q != 9'd0)) begin
         pcnt_d = pcnt_q - 9'd1;
      end
`endif
      unique case (state_q)
         IDLE: begin
            if (eat_req) begin
               ball_x_d = Ball_X;
               ball_y_d = Ball_Y;
               state_d  = CHECK;
            end
         end
         CHECK: begin
            tile_d = ball_tile;
            if ((ball_x_q >= 10'(PLAY_W)) || (ball_y_q >= 10'(PLAY_H)) || !ball_pellet) begin
               state_d = IDLE;
            end else begin
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            map_d[tile_q] = 1'b0;
            left_d        = left_q - 10'd1;
            score_d       = score_sum[16] ? 16'hFFFF : score_sum[15:0];
            state_d       = (left_q == 10'd1) ? DONE : IDLE;
`ifdef FOOD_POWER_PELLET_EN
            if (is_power_tile(tile_q)) begin
               pcnt_d = 9'(POWER_FRAMES);
            end
`endif
         end
         DONE: begin
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
      // Refill wins over anything in flight, including a same-cycle eat_req.
      if (restart) begin
         state_d = IDLE;
         map_d   = '1;
         score_d = 16'd0;
         left_d  = 10'(NUM_TILES);
`ifdef FOOD_POWER_PELLET_EN
         pcnt_d  = 9'd0;
`endif
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= IDLE;
         map_q    <= '1;
         ball_x_q <= 10'd0;
         ball_y_q <= 10'd0;
         tile_q   <= '0;
         score_q  <= 16'd0;
         left_q   <= 10'(NUM_TILES);
`ifdef FOOD_POWER_PELLET_EN
         pcnt_q   <= 9'd0;
`endif
      end else begin
         state_q  <= state_d;
         map_q    <= map_d;
         ball_x_q <= ball_x_d;
         ball_y_q <= ball_y_d;
         tile_q   <= tile_d;
         score_q  <= score_d;
         left_q   <= left_d;
`ifdef FOOD_POWER_PELLET_EN
         pcnt_q   <= pcnt_d;
`endif
      end
   end

   assign score        = score_q;
   assign pellets_left = left_q;
   assign level_clear  = (state_q == DONE);
`ifdef FOOD_POWER_PELLET_EN
   assign power_mode   = (pcnt_q != 9'd0);
`endif

   tile_idx_t draw_tile;
   logic      draw_in_play;
   logic      draw_pellet;
   logic      draw_dot;
   logic [TILE_SHIFT-1:0] dot_lo;
   logic [TILE_SHIFT-1:0] dot_hi;
   logic [TILE_SHIFT-1:0] off_x;
   logic [TILE_SHIFT-1:0] off_y;

   always_comb begin
      draw_tile    = tile_of(DrawX, DrawY);
      draw_in_play = (DrawX < 10'(PLAY_W)) && (DrawY < 10'(PLAY_H));
      draw_pellet  = (draw_tile < tile_idx_t'(NUM_TILES)) && map_q[draw_tile];
      dot_lo       = TILE_SHIFT'(DOT_LO);
      dot_hi       = TILE_SHIFT'(DOT_HI);
`ifdef FOOD_POWER_PELLET_EN
      if (is_power_tile(draw_tile)) begin
         dot_lo = TILE_SHIFT'(PWR_DOT_LO);
         dot_hi = TILE_SHIFT'(PWR_DOT_HI);
      end
`endif
      off_x    = DrawX[TILE_SHIFT-1:0];
      off_y    = DrawY[TILE_SHIFT-1:0];
      draw_dot = (off_x >= dot_lo) && (off_x <= dot_hi) &&
                 (off_y >= dot_lo) && (off_y <= dot_hi);
      // Mapper polarity: low means paint a pellet here.
      is_food  = !(draw_in_play && draw_pellet && draw_dot);
   end

endmodule

// File: tb/tb_food_tracker.sv
// Directed testbench for food_tracker.
module tb_food_tracker;

   logic        Clk;
   logic        Reset;
   logic        frame_clk;
   logic        restart;
   logic [9:0]  Ball_X;
   logic [9:0]  Ball_Y;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        is_food;
   logic [15:0] score;
   logic [9:0]  pellets_left;
   logic        level_clear;
`ifdef FOOD_POWER_PELLET_EN
   logic        power_mode;
   localparam int PTS_T41   = 50;
   localparam int FULL_SCORE = 876 * 10 + 4 * 50;
`else
   localparam int PTS_T41   = 10;
   localparam int FULL_SCORE = 880 * 10;
`endif

   int runs;
   int fails;

   food_tracker dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .frame_clk    (frame_clk),
      .restart      (restart),
      .Ball_X       (Ball_X),
      .Ball_Y       (Ball_Y),
      .DrawX        (DrawX),
      .DrawY        (DrawY),
      .is_food      (is_food),
      .score        (score),
      .pellets_left (pellets_left),
      .level_clear  (level_clear)
`ifdef FOOD_POWER_PELLET_EN
      ,
      .power_mode   (power_mode)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // One frame: 6 cycles high (update lands on the 5th posedge), 4 low.
   task automatic frame_tick();
      @(negedge Clk);
      frame_clk = 1'b1;
      repeat (6) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   task automatic do_restart();
      @(negedge Clk);
      restart = 1'b1;
      @(negedge Clk);
      restart = 1'b0;
   endtask

   task automatic probe(input int x, input int y, input logic exp, input string name);
      DrawX = 10'(x);
      DrawY = 10'(y);
      #1;
      runs++;
      if (is_food !== exp) begin
         fails++;
         $display("FAIL %s (%0d,%0d): is_food=%b expected %b", name, x, y, is_food, exp);
      end
   endtask

   task automatic check_counts(input int exp_score, input int exp_left, input logic exp_lc,
                               input string name);
      runs++;
      if (score !== 16'(exp_score)) begin
         fails++;
         $display("FAIL %s score: got %0d expected %0d", name, score, exp_score);
      end
      runs++;
      if (pellets_left !== 10'(exp_left)) begin
         fails++;
         $display("FAIL %s pellets_left: got %0d expected %0d", name, pellets_left, exp_left);
      end
      runs++;
      if (level_clear !== exp_lc) begin
         fails++;
         $display("FAIL %s level_clear: got %b expected %b", name, level_clear, exp_lc);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      check_counts(0, 880, 1'b0, "reset_hold");
      Reset = 1'b0;
      repeat (2) @(negedge Clk);
      check_counts(0, 880, 1'b0, "reset_release");
      for (int x = 6; x <= 9; x++)
         for (int y = 6; y <= 9; y++)
            probe(x, y, 1'b0, "dot_scan");
      probe(5, 7, 1'b1, "dot_left_edge");
      probe(10, 7, 1'b1, "dot_right_edge");
      probe(7, 5, 1'b1, "dot_top_edge");
      probe(7, 10, 1'b1, "dot_bottom_edge");
      probe(7, 352, 1'b1, "below_playfield");
      probe(647, 7, 1'b1, "right_of_playfield");
      probe(632, 343, 1'b0, "last_tile_dot");
   endtask

   task automatic test_eat();
      Ball_X = 10'd24;
      Ball_Y = 10'd24;
      @(negedge Clk);
      frame_clk = 1'b1;
      repeat (4) @(negedge Clk);
      check_counts(0, 880, 1'b0, "eat_before_latency");
      @(negedge Clk);
      check_counts(PTS_T41, 879, 1'b0, "eat_at_latency");
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
      probe(24, 24, 1'b1, "eaten_tile41");
      probe(8, 24, 1'b0, "neighbour_tile40");
   endtask

   task automatic test_repeat_same_tile();
      frame_tick();
      check_counts(PTS_T41, 879, 1'b0, "second_frame_same_tile");
   endtask

   task automatic test_out_of_range();
      Ball_X = 10'd650;
      Ball_Y = 10'd24;
      frame_tick();
      check_counts(PTS_T41, 879, 1'b0, "ball_x_650");
      probe(8, 40, 1'b0, "alias_tile80_kept");
      Ball_X = 10'd8;
      Ball_Y = 10'd352;
      frame_tick();
      check_counts(PTS_T41, 879, 1'b0, "ball_y_352");
   endtask

   task automatic test_restart_coincident();
      Ball_X = 10'd8;
      Ball_Y = 10'd8;
      @(negedge Clk);
      frame_clk = 1'b1;
      repeat (2) @(negedge Clk);
      restart = 1'b1;
      @(negedge Clk);
      restart = 1'b0;
      repeat (5) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
      check_counts(0, 880, 1'b0, "restart_vs_eat");
      probe(8, 8, 1'b0, "tile0_survives");
      probe(24, 24, 1'b0, "tile41_refilled");
   endtask

   task automatic test_level_clear();
      int n;
      do_restart();
      n = 0;
      for (int r = 0; r < 22; r++) begin
         for (int c = 0; c < 40; c++) begin
            Ball_X = 10'(c * 16 + 8);
            Ball_Y = 10'(r * 16 + 8);
            frame_tick();
            n++;
            runs++;
            if (pellets_left !== 10'(880 - n)) begin
               fails++;
               $display("FAIL clear_walk tile %0d: pellets_left=%0d expected %0d",
                        n - 1, pellets_left, 880 - n);
            end
            if (n == 879) check_counts(FULL_SCORE - 10, 1, 1'b0, "one_left");
         end
      end
      check_counts(FULL_SCORE, 0, 1'b1, "level_cleared");
      probe(8, 8, 1'b1, "map_empty");
      Ball_X = 10'd8;
      Ball_Y = 10'd8;
      frame_tick();
      check_counts(FULL_SCORE, 0, 1'b1, "done_ignores_frames");
      do_restart();
      check_counts(0, 880, 1'b0, "restart_from_done");
   endtask

   task automatic test_reset_mid_clear();
      Ball_X = 10'd8;
      Ball_Y = 10'd8;
      frame_tick();
      check_counts(10, 879, 1'b0, "pre_reset_eat");
      Ball_X = 10'd24;
      @(negedge Clk);
      frame_clk = 1'b1;
      repeat (4) @(posedge Clk);
      #1;
      Reset = 1'b1;
      #1;
      check_counts(0, 880, 1'b0, "reset_mid_clear");
      probe(8, 8, 1'b0, "reset_refills_tile0");
      probe(24, 8, 1'b0, "reset_keeps_tile1");
      frame_clk = 1'b0;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      repeat (4) @(negedge Clk);
      check_counts(0, 880, 1'b0, "after_reset_release");
   endtask

`ifdef FOOD_POWER_PELLET_EN
   task automatic test_power();
      do_restart();
      probe(20, 20, 1'b0, "power_dot_big");
      Ball_X = 10'd24;
      Ball_Y = 10'd24;
      frame_tick();
      check_counts(50, 879, 1'b0, "power_eat");
      runs++;
      if (power_mode !== 1'b1) begin
         fails++;
         $display("FAIL power_on: power_mode=%b expected 1", power_mode);
      end
      Ball_X = 10'd650;
      repeat (299) frame_tick();
      runs++;
      if (power_mode !== 1'b1) begin
         fails++;
         $display("FAIL power_frame300: power_mode=%b expected 1", power_mode);
      end
      frame_tick();
      runs++;
      if (power_mode !== 1'b0) begin
         fails++;
         $display("FAIL power_frame301: power_mode=%b expected 0", power_mode);
      end
   endtask
`endif

   initial begin
      runs      = 0;
      fails     = 0;
      Reset     = 1'b1;
      frame_clk = 1'b0;
      restart   = 1'b0;
      Ball_X    = 10'd0;
      Ball_Y    = 10'd0;
      DrawX     = 10'd0;
      DrawY     = 10'd0;
      test_reset();
      test_eat();
      test_repeat_same_tile();
      test_out_of_range();
      test_restart_coincident();
      test_level_clear();
      test_reset_mid_clear();
`ifdef FOOD_POWER_PELLET_EN
      test_power();
`endif
      $display("[TB] %0d tests run, %0d failed", runs, fails);
      $finish;
   end

endmodule
